alu_regfile_datapath: RTL and testbench

Single-cycle execute datapath for the pipelined RISC-V core: a register file feeding a combinational ALU, with the ALU result written back to the register file on the clock edge. Operand 1 is read from the register file; operand 2 is an immediate/bypass value supplied by the caller. A second read port exposes register contents for debug and verification.

---
 rtl/alu_regfile_datapath_if.sv | 25 ++
 rtl/alu_regfile_datapath.sv | 67 ++++++
 tb/tb_alu_regfile_datapath.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_regfile_datapath_if.sv
// Execute-stage bundle: operation request, combinational result and debug read port.
// The master drives the request and debug address; the slave returns out and dbg_data.
interface alu_regfile_datapath_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            we;
  logic [3:0]      op;
  logic [AW-1:0]   dst;
  logic [AW-1:0]   src1;
  logic [XLEN-1:0] val2;
  logic [XLEN-1:0] out;
  logic [AW-1:0]   dbg_addr;
  logic [XLEN-1:0] dbg_data;

  modport master (
    output we, op, dst, src1, val2, dbg_addr,
    input  out, dbg_data
  );

  modport slave (
    input  we, op, dst, src1, val2, dbg_addr,
    output out, dbg_data
  );
endinterface

// File: rtl/alu_regfile_datapath.sv
// Register file + combinational ALU with write-back on the rising edge; zero-latency result.
// No backpressure: one operation accepted every clock, no stalls or handshake.
module alu_regfile_datapath #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  alu_regfile_datapath_if.slave  bus
);
  localparam int SHW = $clog2(XLEN);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SHL  = 4'd2,
    OP_SHR  = 4'd3,
    OP_SRA  = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_XOR  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9
  } alu_op_e;

  logic [XLEN-1:0] rf [NREGS];
  logic [XLEN-1:0] opa;
  logic [XLEN-1:0] opb;
  logic [XLEN-1:0] res;
  logic [SHW-1:0]  shamt;

  // x0 is hardwired to zero on every read port; its storage is never written.
  assign opa          = (bus.src1 == '0) ? '0 : rf[bus.src1];
  assign bus.dbg_data = (bus.dbg_addr == '0) ? '0 : rf[bus.dbg_addr];
  assign opb          = bus.val2;
  assign shamt        = opb[SHW-1:0];

  always_comb begin
    res = '0;
    case (alu_op_e'(bus.op))
      OP_ADD:  res = opa + opb;
      OP_SUB:  res = opa - opb;
      OP_SHL:  res = opa << shamt;
      OP_SHR:  res = opa >> shamt;
      OP_SRA:  res = $signed(opa) >>> shamt;
      OP_AND:  res = opa & opb;
      OP_OR:   res = opa | opb;
      OP_XOR:  res = opa ^ opb;
      OP_SLT:  res = {{(XLEN-1){1'b0}}, ($signed(opa) < $signed(opb))};
      OP_SLTU: res = {{(XLEN-1){1'b0}}, (opa < opb)};
      default: res = '0;
    endcase
  end

  assign bus.out = res;

  // No write-to-read bypass: a same-cycle reader sees the pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        rf[i] <= '0;
      end
    end else if (bus.we && (bus.dst != '0)) begin
      rf[bus.dst] <= res;
    end
  end
endmodule

// File: tb/tb_alu_regfile_datapath.sv
// Randomised and directed checks of the execute datapath against an arithmetic reference model.
module tb_alu_regfile_datapath;
  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  logic [31:0] m_rf [32];

  alu_regfile_datapath_if #(.XLEN(32), .AW(5)) bus ();

  alu_regfile_datapath #(.XLEN(32), .NREGS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU built from plain integer arithmetic on 64-bit values.
  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    longint ua, ub, sa, sb, p, r;
    int     sh;
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= 64'sh8000_0000) ? ua - 64'sh1_0000_0000 : ua;
    sb = (ub >= 64'sh8000_0000) ? ub - 64'sh1_0000_0000 : ub;
    sh = int'(ub % 32);
    p  = 64'sd1 << sh;
    case (op)
      0: r = ua + ub;
      1: r = ua + 64'sh1_0000_0000 - ub;
      2: r = ua * p;
      3: r = ua / p;
      4: r = (sa < 0) ? -((-sa + p - 1) / p) : sa / p;
      5: r = longint'(a & b);
      6: r = longint'(a | b);
      7: r = longint'(a ^ b);
      8: r = (sa < sb) ? 1 : 0;
      9: r = (ua < ub) ? 1 : 0;
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  task automatic drive(input logic w, input int op, input int d, input int s, input logic [31:0] v);
    bus.we   = w;
    bus.op   = 4'(op);
    bus.dst  = 5'(d);
    bus.src1 = 5'(s);
    bus.val2 = v;
    #1;
  endtask

  // Advance one clock and apply the architectural write-back to the model.
  task automatic tick();
    logic [31:0] r;
    logic        w;
    int          d;
    r = ref_alu(int'(bus.op), m_rf[bus.src1], bus.val2);
    w = bus.we;
    d = int'(bus.dst);
    @(posedge clk);
    if (w && rst_n && d != 0) m_rf[d] = r;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 0, 4, 0, 32'd77);
    for (int a = 0; a < 32; a++) begin
      bus.dbg_addr = 5'(a);
      #1;
      n_total++;
      if (bus.dbg_data !== 32'd0) $display("FAIL reset_dbg x%0d got %h want 0", a, bus.dbg_data);
      else n_pass++;
    end
    n_total++;
    if (bus.out !== 32'd77) $display("FAIL reset_out got %h want %h", bus.out, 32'd77);
    else n_pass++;
    drive(1'b0, 0, 0, 0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
  endtask

  task automatic test_chain();
    logic [31:0] want [6];
    want = '{32'd0, 32'd80, 32'd81, 32'd82, 32'd83, 32'd84};
    drive(1'b1, 0, 1, 0, 32'd10);
    n_total++;
    if (bus.out !== 32'd10) $display("FAIL chain_add got %0d want 10", bus.out);
    else n_pass++;
    tick();
    drive(1'b1, 2, 1, 1, 32'd3);
    n_total++;
    if (bus.out !== 32'd80) $display("FAIL chain_shl got %0d want 80", bus.out);
    else n_pass++;
    tick();
    for (int r = 2; r <= 5; r++) begin
      drive(1'b1, 0, r, r - 1, 32'd1);
      tick();
    end
    bus.we = 1'b0;
    for (int r = 1; r <= 5; r++) begin
      bus.dbg_addr = 5'(r);
      #1;
      n_total++;
      if (bus.dbg_data !== want[r]) $display("FAIL chain_dbg x%0d got %0d want %0d", r, bus.dbg_data, want[r]);
      else n_pass++;
    end
  endtask

  task automatic test_x0();
    drive(1'b1, 0, 0, 0, 32'd5);
    tick();
    bus.dbg_addr = 5'd0;
    drive(1'b0, 0, 0, 0, 32'd7);
    n_total++;
    if (bus.dbg_data !== 32'd0) $display("FAIL x0_dbg got %h want 0", bus.dbg_data);
    else n_pass++;
    n_total++;
    if (bus.out !== 32'd7) $display("FAIL x0_read got %0d want 7", bus.out);
    else n_pass++;
  endtask

  task automatic test_alu_sweep();
    int          ops  [11];
    logic [31:0] want [11];
    ops  = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 12};
    want = '{32'hFFFF_FFF4, 32'hFFFF_FFEC, 32'hFFFF_FF00, 32'h0FFF_FFFF, 32'hFFFF_FFFF,
             32'h0, 32'hFFFF_FFF4, 32'hFFFF_FFF4, 32'h1, 32'h0, 32'h0};
    drive(1'b1, 0, 1, 0, 32'hFFFF_FFF0);
    tick();
    for (int i = 0; i < 11; i++) begin
      drive(1'b0, ops[i], 0, 1, 32'd4);
      n_total++;
      if (bus.out !== want[i]) $display("FAIL sweep_op%0d got %h want %h", ops[i], bus.out, want[i]);
      else n_pass++;
    end
  endtask

  task automatic test_wrap_shift();
    drive(1'b1, 0, 1, 0, 32'hFFFF_FFFF);
    tick();
    drive(1'b0, 0, 0, 1, 32'd1);
    n_total++;
    if (bus.out !== 32'd0) $display("FAIL wrap_add got %h want 0", bus.out);
    else n_pass++;
    drive(1'b0, 2, 0, 1, 32'h21);
    n_total++;
    if (bus.out !== 32'hFFFF_FFFE) $display("FAIL shift_mask got %h want fffffffe", bus.out);
    else n_pass++;
  endtask

  task automatic test_we_hazard();
    drive(1'b1, 0, 2, 0, 32'd55);
    tick();
    drive(1'b0, 0, 2, 0, 32'd99);
    tick();
    bus.dbg_addr = 5'd2;
    #1;
    n_total++;
    if (bus.dbg_data !== 32'd55) $display("FAIL we0_hold got %0d want 55", bus.dbg_data);
    else n_pass++;
    drive(1'b1, 0, 3, 0, 32'd9);
    tick();
    bus.dbg_addr = 5'd3;
    drive(1'b1, 0, 3, 0, 32'd42);
    n_total++;
    if (bus.dbg_data !== 32'd9) $display("FAIL no_bypass got %0d want 9", bus.dbg_data);
    else n_pass++;
    tick();
    drive(1'b1, 0, 3, 3, 32'd5);
    n_total++;
    if (bus.out !== 32'd47) $display("FAIL hazard_pre got %0d want 47", bus.out);
    else n_pass++;
    tick();
    bus.we = 1'b0;
    #1;
    n_total++;
    if (bus.out !== 32'd52) $display("FAIL hazard_rmw got %0d want 52", bus.out);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      logic [31:0] v, e;
      int          op, s, a;
      op = int'($urandom_range(0, 15));
      s  = int'($urandom_range(0, 31));
      v  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      drive(1'($urandom_range(0, 1)), op, int'($urandom_range(0, 31)), s, v);
      a = int'($urandom_range(0, 31));
      bus.dbg_addr = 5'(a);
      #1;
      e = ref_alu(op, m_rf[s], v);
      n_total++;
      if (bus.out !== e) $display("FAIL rand_out op%0d x%0d got %h want %h", op, s, bus.out, e);
      else n_pass++;
      n_total++;
      if (bus.dbg_data !== m_rf[a]) $display("FAIL rand_dbg x%0d got %h want %h", a, bus.dbg_data, m_rf[a]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 0, 5, 0, 32'd123);
    tick();
    bus.dbg_addr = 5'd5;
    drive(1'b1, 0, 7, 5, 32'd3);
    rst_n = 1'b0;
    #1;
    n_total++;
    if (bus.dbg_data !== 32'd0) $display("FAIL async_clear got %0d want 0", bus.dbg_data);
    else n_pass++;
    n_total++;
    if (bus.out !== 32'd3) $display("FAIL async_out got %0d want 3", bus.out);
    else n_pass++;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    @(posedge clk);
    #1;
    for (int a = 0; a < 32; a++) begin
      bus.dbg_addr = 5'(a);
      #1;
      n_total++;
      if (bus.dbg_data !== 32'd0) $display("FAIL async_dbg x%0d got %h want 0", a, bus.dbg_data);
      else n_pass++;
    end
    bus.we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.dbg_addr = 5'd7;
    #1;
    n_total++;
    if (bus.dbg_data !== 32'd0) $display("FAIL reset_write_blocked got %0d want 0", bus.dbg_data);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    bus.dbg_addr = 5'd0;
    test_reset();
    test_chain();
    test_x0();
    test_alu_sweep();
    test_wrap_shift();
    test_we_hazard();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
